// File: rtl/filter2d_pkg.sv
// filter2d_pkg: frame geometry defaults and sink FSM state encodings
package filter2d_pkg;
  localparam int DEF_WIDTH = 256;
  localparam int DEF_HEIGHT = 256;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/filter2d_sink_ram.sv
// filter2d_sink_ram: 2**ADDR_W x 8 dual-port frame RAM, one write port, registered read-first read port (we/wr_addr/wr_data in, rd_en/rd_addr in, rd_data out)
module filter2d_sink_ram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);
  logic [7:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[wr_addr] <= wr_data;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/filter2d_sink.sv
// filter2d_sink: captures a filter2d pixel stream into a frame RAM with row/col tracking, done/overflow flags, host read port and optional checksum (FILTER2D_SINK_CHECKSUM_EN)
module filter2d_sink
  import filter2d_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              i_strb,
  input  logic [7:0]        i_data,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_ovf,
  output logic [7:0]        o_row,
  output logic [7:0]        o_col,
  output logic [15:0]       o_sum
);
  localparam int LOG_W = $clog2(WIDTH);
  logic [1:0] state;
  logic [7:0] row, col;
  logic we, last_col, last_px;
  logic [ADDR_W-1:0] wr_addr;
  always_comb begin
    we = i_strb && !clear && state != ST_DONE;
    last_col = col == 8'(WIDTH - 1);
    last_px = last_col && row == 8'(HEIGHT - 1);
    wr_addr = (ADDR_W'(row) << LOG_W) | ADDR_W'(col);
  end
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      state <= ST_IDLE;
      row <= '0;
      col <= '0;
      o_ovf <= 1'b0;
    end else if (clear) begin
      state <= ST_IDLE;
      row <= '0;
      col <= '0;
      o_ovf <= 1'b0;
    end else if (state == ST_DONE) begin
      if (i_strb) o_ovf <= 1'b1;
    end else if (i_strb) begin
      col <= last_col ? '0 : col + 8'd1;
      row <= last_px ? '0 : last_col ? row + 8'd1 : row;
      state <= last_px ? ST_DONE : ST_CAPTURE;
    end
  assign o_busy = state == ST_CAPTURE;
  assign o_done = state == ST_DONE;
  assign o_row = row;
  assign o_col = col;
`ifdef FILTER2D_SINK_CHECKSUM_EN
  logic [15:0] sum;
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) sum <= '0;
    else if (clear) sum <= '0;
    else if (we) sum <= sum + 16'(i_data);
  assign o_sum = sum;
`else
  assign o_sum = '0;
`endif
  filter2d_sink_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .n_reset(n_reset),
    .we(we),
    .wr_addr(wr_addr),
    .wr_data(i_data),
    .rd_en(rd_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_filter2d_sink.sv
// tb_filter2d_sink: randomized scoreboard bench for filter2d_sink against a frame-level reference model
module tb_filter2d_sink;
  logic clk = 0, n_reset = 0, i_strb = 0, clear = 0, rd_en = 0;
  logic [7:0] i_data = 0;
  logic [15:0] rd_addr = 0;
  logic [7:0] rd_data, o_row, o_col;
  logic o_busy, o_done, o_ovf;
  logic [15:0] o_sum;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  filter2d_sink dut (
    .clk(clk), .n_reset(n_reset), .i_strb(i_strb), .i_data(i_data), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .o_busy(o_busy),
    .o_done(o_done), .o_ovf(o_ovf), .o_row(o_row), .o_col(o_col), .o_sum(o_sum)
  );
  logic [7:0] mem_m [65536];
  bit wr_m [65536];
  int idx = 0, st = 0;
  bit ovf_m = 0;
  logic [15:0] sum_m = 0;
  logic [7:0] exp_q [$];
  logic rd_pend = 0;
  always @(posedge clk) rd_pend <= rd_en;
  always @(negedge clk)
    if (rd_pend) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: got %02h with no expected read queued", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %02h expected %02h", rd_data, e);
        end
      end
    end
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic status(input string tag);
    chk({tag, ".busy"}, 16'(o_busy), 16'(st == 1));
    chk({tag, ".done"}, 16'(o_done), 16'(st == 2));
    chk({tag, ".ovf"}, 16'(o_ovf), 16'(ovf_m));
    chk({tag, ".row"}, 16'(o_row), 16'((idx / 256) % 256));
    chk({tag, ".col"}, 16'(o_col), 16'(idx % 256));
`ifdef FILTER2D_SINK_CHECKSUM_EN
    chk({tag, ".sum"}, o_sum, sum_m);
`else
    chk({tag, ".sum"}, o_sum, 16'h0);
`endif
  endtask
  task automatic model_reset();
    idx = 0;
    st = 0;
    ovf_m = 0;
    sum_m = 0;
  endtask
  task automatic cyc(input bit s, input logic [7:0] d, input bit c, input bit re, input logic [15:0] ra);
    i_strb = s;
    i_data = d;
    clear = c;
    rd_en = re;
    rd_addr = ra;
    if (re) exp_q.push_back(mem_m[ra]);
    if (c) model_reset();
    else if (s) begin
      if (st == 2) ovf_m = 1;
      else begin
        mem_m[idx] = d;
        wr_m[idx] = 1;
        sum_m = sum_m + 16'(d);
        idx++;
        st = (idx == 65536) ? 2 : 1;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    bit re;
    int ra;
    repeat (3) @(negedge clk);
    n_reset = 1;
    status("reset");
    chk("reset.rd_data", 16'(rd_data), 16'h0);
    for (int k = 0; k < 3 * 256 + 10; k++) cyc(1, 8'($urandom), 0, 0, 0);
    status("partial");
    cyc(0, 0, 0, 1, 16'd5);
    cyc(0, 0, 0, 1, 16'd300);
    cyc(0, 0, 0, 0, 0);
    #2 n_reset = 0;
    #1 model_reset();
    status("async");
    chk("async.rd_data", 16'(rd_data), 16'h0);
    @(negedge clk);
    n_reset = 1;
    for (int k = 0; k < 5; k++) cyc(1, 8'(8'hA0 + k), 0, 0, 0);
    status("rearm5");
    cyc(0, 0, 0, 1, 16'd0);
    cyc(1, 8'h5A, 1, 0, 0);
    status("clrstrb");
    cyc(0, 0, 0, 1, 16'd5);
    cyc(0, 0, 0, 1, 16'd4);
    while (st != 2) begin
      re = $urandom_range(7) == 0 || idx == 16;
      ra = (idx == 16 || ($urandom_range(1) == 1 && wr_m[idx])) ? idx : (idx == 0 ? 0 : int'($urandom_range(idx - 1)));
      if (idx == 65535) chk("predone.done", 16'(o_done), 16'h0);
      if (idx == 32768) status("midframe");
      if ($urandom_range(31) == 0) cyc(0, 0, 0, re, 16'(ra));
      else cyc(1, 8'((idx / 256) + (idx % 256)), 0, re, 16'(ra));
    end
    status("frame");
    cyc(0, 0, 0, 1, 16'h0102);
    cyc(0, 0, 0, 1, 16'hFFFF);
    cyc(0, 0, 0, 1, 16'h0010);
    for (int k = 0; k < 5; k++) cyc(1, 8'($urandom), 0, 0, 0);
    status("ovf");
    cyc(0, 0, 0, 1, 16'h0000);
    cyc(0, 0, 0, 1, 16'h0102);
    cyc(0, 0, 1, 0, 0);
    status("clear");
    cyc(0, 0, 0, 1, 16'h8080);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("queue.empty", 16'(exp_q.size()), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
